alu_cmd_ctrl: RTL

Command sequencer between the UART receive/transmit byte streams and the 32-bit accumulating adder. Parses a 4-byte packet header from the RX stream, forwards the operand payload to the adder with the start/valid protocol it requires, waits for the adder's done pulse, then returns the 32-bit result MSB-first on the TX stream. Unsupported opcodes and stalled adders are answered with a single error byte so the host never hangs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_ctrl_byte_serializer.sv | 48 ++++
 rtl/alu_cmd_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_pkg;

    typedef enum logic [3:0] {
        StOp,
        StRsv,
        StLenLo,
        StLenHi,
        StStart,
        StStream,
        StWaitDone,
        StTx,
        StDrain,
        StErr
    } ctrl_state_e;

    localparam logic [7:0] OP_ADD    = 8'hA0;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/alu_cmd_ctrl_byte_serializer.sv
// Registered word-to-byte shifter with valid/ready; sends i_nbytes bytes, MSB first.
module byte_serializer #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic [BYTE_W*NBYTES-1:0] i_data,
    input  logic [CNT_W-1:0]         i_nbytes,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [BYTE_W-1:0]        o_data,
    output logic                     o_done
);

    localparam int unsigned W = BYTE_W * NBYTES;

    logic [W-1:0]     r_shift;
    logic [CNT_W-1:0] r_left;
    logic             r_valid;
    logic             w_fire;

    assign w_fire = r_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_left  <= i_nbytes;
            r_valid <= (i_nbytes != '0);
        end else if (w_fire) begin
            // Next byte becomes visible the cycle after the handshake.
            r_shift <= {r_shift[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            r_left  <= r_left - CNT_W'(1);
            r_valid <= (r_left != CNT_W'(1));
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_shift[W-1 -: BYTE_W];
    assign o_done  = w_fire & (r_left == CNT_W'(1));

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Packet parser between the UART byte streams and the accumulating adder;
// forwards operands, waits for the sum and returns it (or an error byte) on TX.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned          datawidth_p = 8,
    parameter int unsigned          timeout_p   = 1024,
    parameter logic [datawidth_p-1:0] op_add_p  = OP_ADD,
    parameter logic [datawidth_p-1:0] err_byte_p = ERR_BYTE
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    output logic                   rx_ready_o,
    output logic                   tx_valid_o,
    output logic [datawidth_p-1:0] tx_data_o,
    input  logic                   tx_ready_i,
    output logic                   add_start_o,
    output logic                   add_valid_o,
    output logic [datawidth_p-1:0] add_data_o,
    output logic [15:0]            add_len_o,
    input  logic                   add_done_i,
    input  logic [31:0]            add_result_i
);

    localparam int unsigned TW   = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam int unsigned NB_W = $clog2(HDR_BYTES) + 1;
    localparam int unsigned WW   = 4 * datawidth_p;

    ctrl_state_e            r_state;
    ctrl_state_e            w_next;
    logic [datawidth_p-1:0] r_opcode;
    logic [15:0]            r_len;
    logic [17:0]            r_cnt;
    logic [TW-1:0]          r_tout;

    logic                   w_rdy_st;
    logic                   w_acc;
    logic [15:0]            w_len_full;
    logic [17:0]            w_cnt_load;
    logic                   w_ser_load;
    logic [WW-1:0]          w_ser_data;
    logic [NB_W-1:0]        w_ser_n;
    logic                   w_ser_done;

    assign w_len_full = {rx_data_i[7:0], r_len[7:0]};
    assign w_cnt_load = {w_len_full, 2'b00} - 18'd1;
    assign w_acc      = rx_valid_i & rx_ready_o;

    always_comb begin
        w_next     = r_state;
        w_rdy_st   = 1'b0;
        w_ser_load = 1'b0;
        w_ser_data = '0;
        w_ser_n    = '0;
        case (r_state)
            StOp: begin
                w_rdy_st = 1'b1;
                if (w_acc) w_next = StRsv;
            end
            StRsv: begin
                w_rdy_st = 1'b1;
                if (w_acc) w_next = StLenLo;
            end
            StLenLo: begin
                w_rdy_st = 1'b1;
                if (w_acc) w_next = StLenHi;
            end
            StLenHi: begin
                w_rdy_st = 1'b1;
                if (w_acc) begin
                    if (r_opcode != op_add_p) begin
                        if (w_len_full == 16'd0) begin
                            w_next     = StErr;
                            w_ser_load = 1'b1;
                            w_ser_data = {err_byte_p, {(3*datawidth_p){1'b0}}};
                            w_ser_n    = NB_W'(1);
                        end else begin
                            w_next = StDrain;
                        end
                    end else if (w_len_full == 16'd0) begin
                        // Empty ADD never touches the adder; the answer is zero.
                        w_next     = StTx;
                        w_ser_load = 1'b1;
                        w_ser_n    = NB_W'(4);
                    end else begin
                        w_next = StStart;
                    end
                end
            end
            StStart, StStream: begin
                w_rdy_st = 1'b1;
                if (w_acc) w_next = (r_cnt == 18'd0) ? StWaitDone : StStream;
            end
            StWaitDone: begin
                if (add_done_i) begin
                    w_next     = StTx;
                    w_ser_load = 1'b1;
                    w_ser_data = add_result_i;
                    w_ser_n    = NB_W'(4);
                end else if (r_tout == TW'(timeout_p - 1)) begin
                    w_next     = StErr;
                    w_ser_load = 1'b1;
                    w_ser_data = {err_byte_p, {(3*datawidth_p){1'b0}}};
                    w_ser_n    = NB_W'(1);
                end
            end
            StDrain: begin
                w_rdy_st = 1'b1;
                if (w_acc && r_cnt == 18'd0) begin
                    w_next     = StErr;
                    w_ser_load = 1'b1;
                    w_ser_data = {err_byte_p, {(3*datawidth_p){1'b0}}};
                    w_ser_n    = NB_W'(1);
                end
            end
            StTx, StErr: begin
                if (w_ser_done) w_next = StOp;
            end
            default: w_next = StOp;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StOp;
            r_opcode <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_tout   <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                case (r_state)
                    StOp:    r_opcode <= rx_data_i;
                    StLenLo: r_len[7:0] <= rx_data_i[7:0];
                    StLenHi: begin
                        r_len[15:8] <= rx_data_i[7:0];
                        r_cnt       <= w_cnt_load;
                    end
                    StStart, StStream, StDrain: begin
                        if (r_cnt != 18'd0) r_cnt <= r_cnt - 18'd1;
                    end
                    default: ;
                endcase
            end
            r_tout <= (r_state == StWaitDone) ? r_tout + TW'(1) : '0;
        end
    end

    // Ready is masked by reset so the host sees 0 for the whole reset window.
    assign rx_ready_o  = w_rdy_st & rst_ni;
    assign add_start_o = (r_state == StStart) & rx_valid_i;
    assign add_valid_o = (r_state == StStream) & rx_valid_i;
    assign add_data_o  = rx_data_i;
    assign add_len_o   = r_len;

    byte_serializer #(
        .BYTE_W (datawidth_p),
        .NBYTES (4),
        .CNT_W  (NB_W)
    ) u_ser (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_load   (w_ser_load),
        .i_data   (w_ser_data),
        .i_nbytes (w_ser_n),
        .i_ready  (tx_ready_i),
        .o_valid  (tx_valid_o),
        .o_data   (tx_data_o),
        .o_done   (w_ser_done)
    );

endmodule
